pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Generates enable, flush and bubble controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- Handles data-memory wait, load-use hazards, taken-branch squash and halt draining.
- Replaces per-latch ad-hoc stall muxing with one FSM-driven source of truth.

Parameters:
- BR_FLUSH, 1, cycles IF/ID is flushed per taken branch, counting the resolution cycle (legal 1..15).
- DRAIN_CYCLES, 3, cycles after halt acceptance before halt_done asserts (legal 1..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  IF/ID holds a real instruction
- id_rs  in  3  source register A of instruction in ID
- id_rs_used  in  1  instruction in ID reads rs
- id_rt  in  3  source register B of instruction in ID
- id_rt_used  in  1  instruction in ID reads rt
- id_halt  in  1  instruction in ID is HALT
- idex_memread  in  1  instruction in EX is a load
- idex_regwrt  in  1  instruction in EX writes a register
- idex_rd  in  3  destination register of instruction in EX
- ex_br_taken  in  1  branch/jump in EX resolved taken
- mem_busy  in  1  data memory not done; freezes pipeline
- pc_en  out  1  PC update enable
- ifid_en  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID loads a NOP
- idex_en  out  1  ID/EX load enable
- idex_bubble  out  1  ID/EX loads a NOP (control zeroed)
- exmem_en  out  1  EX/MEM load enable
- memwb_en  out  1  MEM/WB load enable
- halt_done  out  1  pipeline drained after HALT
- stall_cnt  out  16  saturating count of stall cycles
- state  out  3  FSM state (debug)

Behaviour:
- FSM states: RUN=0, FLUSH=1, DRAIN=2, HALTED=3.
- Internal 4-bit counter cnt.
- Reset: state=RUN, cnt=0, stall_cnt=0.
- While rst=1, all enables, ifid_flush, idex_bubble and halt_done are 0 (combinationally masked).
- Outputs are combinational from state, cnt and current inputs. State, cnt and stall_cnt update on the clk rising edge.
- Freeze, highest priority, any state except HALTED:
  - mem_busy=1 drives all five enables to 0 and ifid_flush=idex_bubble=0.
  - state and cnt hold.
  - stall_cnt increments.
- Load-use hazard: hz = id_valid & idex_memread & idex_regwrt & ((id_rs_used & id_rs==idex_rd) | (id_rt_used & id_rt==idex_rd)).
- RUN, priority order:
  - ex_br_taken=1: pc_en=1, ifid_flush=1, idex_bubble=1, all other enables=1. If BR_FLUSH>1, go to FLUSH with cnt=BR_FLUSH-1; otherwise stay in RUN. Branch beats hz and id_halt, since the ID instruction is wrong-path.
  - hz=1: pc_en=0, ifid_en=0, idex_bubble=1, downstream enables=1, stall_cnt++. Stay in RUN (one-cycle stall, hazard clears next cycle). hz beats id_halt.
  - id_valid & id_halt: all enables=1, so HALT moves to EX. Then pc_en=0, ifid_en=0 for this cycle. Go to DRAIN with cnt=DRAIN_CYCLES.
  - Otherwise: all enables=1, no flush, no bubble.
- FLUSH:
  - pc_en=1, ifid_flush=1, idex_bubble=1, downstream enables=1.
  - cnt decrements; when cnt==1 at the edge, go to RUN.
  - A new ex_br_taken in FLUSH cannot occur (EX holds a bubble) and is ignored.
- DRAIN:
  - pc_en=0, ifid_en=0, idex_bubble=1, idex_en/exmem_en/memwb_en=1.
  - ex_br_taken and hz are ignored.
  - cnt decrements per non-frozen cycle; when cnt==1 at the edge, go to HALTED.
- HALTED:
  - All enables 0, flush=bubble=0, halt_done=1.
  - mem_busy is ignored. Only rst exits.
- stall_cnt: +1 on each non-reset cycle where pc_en=0 in RUN or DRAIN, or on any freeze cycle. Saturates at 16'hFFFF. Not incremented in HALTED.
- Reset mid-operation (any state, any cnt): next edge gives state=RUN, cnt=0, stall_cnt=0, no residual flush.
- x0–x7 all compare. There is no r0 special case.

Test Plan:
- Load-use: idex_memread=1, idex_regwrt=1, idex_rd=3, id_valid=1, id_rs=3, id_rs_used=1 for 1 cycle -> pc_en=0, ifid_en=0, idex_bubble=1, exmem_en=1; stall_cnt 0->1. With id_rs_used=0 -> no stall.
- Branch with BR_FLUSH=2: ex_br_taken=1 -> ifid_flush=1, idex_bubble=1, pc_en=1 that cycle and the next; state 0->1->0. Same cycle as hz=1 -> no pc stall, stall_cnt unchanged.
- Memory freeze: mem_busy=1 for 4 cycles while in FLUSH (cnt=1) -> all enables 0, state stays 1; stall_cnt +4; FLUSH completes on the first cycle after mem_busy=0.
- Halt with DRAIN_CYCLES=3: id_valid=1, id_halt=1 -> DRAIN for 3 cycles with idex_bubble=1, then HALTED with halt_done=1 and all enables 0; a mem_busy pulse mid-drain extends the drain by its length.
- Halt vs branch: id_halt=1 and ex_br_taken=1 same cycle -> flush taken, state stays RUN, halt_done stays 0.
- Reset: assert rst in DRAIN (cnt=2) -> following cycle state=0, stall_cnt=0, halt_done=0; saturation check: preload 16'hFFFE plus 3 stall cycles -> 16'hFFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Central stall/flush/bubble sequencer for a 5-stage pipeline:
//                memory freeze, load-use stall, branch squash, halt drain.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int BR_FLUSH     = 1,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [2:0]  id_rs,
    input  logic        id_rs_used,
    input  logic [2:0]  id_rt,
    input  logic        id_rt_used,
    input  logic        id_halt,
    input  logic        idex_memread,
    input  logic        idex_regwrt,
    input  logic [2:0]  idex_rd,
    input  logic        ex_br_taken,
    input  logic        mem_busy,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_en,
    output logic        idex_bubble,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        halt_done,
    output logic [15:0] stall_cnt,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_FLUSH  = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_HALTED = 3'd3
    } state_t;

    localparam logic [3:0] c_br_init    = 4'(BR_FLUSH - 1);
    localparam logic [3:0] c_drain_init = 4'(DRAIN_CYCLES);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [15:0] r_stall_cnt;
    logic        w_hz;
    logic        w_stall_inc;
    logic        w_pc_en, w_ifid_en, w_ifid_flush, w_idex_en;
    logic        w_idex_bubble, w_exmem_en, w_memwb_en, w_halt_done;

    assign w_hz = id_valid & idex_memread & idex_regwrt &
                  ((id_rs_used & (id_rs == idex_rd)) |
                   (id_rt_used & (id_rt == idex_rd)));

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_stall_inc   = 1'b0;
        w_pc_en       = 1'b0;
        w_ifid_en     = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_en     = 1'b0;
        w_idex_bubble = 1'b0;
        w_exmem_en    = 1'b0;
        w_memwb_en    = 1'b0;
        w_halt_done   = 1'b0;
        // Reset masks every control; freeze holds state and cnt outright.
        if (!rst) begin
            if ((r_state != ST_HALTED) && mem_busy) begin
                w_stall_inc = 1'b1;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        w_idex_en  = 1'b1;
                        w_exmem_en = 1'b1;
                        w_memwb_en = 1'b1;
                        if (ex_br_taken) begin
                            w_pc_en       = 1'b1;
                            w_ifid_en     = 1'b1;
                            w_ifid_flush  = 1'b1;
                            w_idex_bubble = 1'b1;
                            if (BR_FLUSH > 1) begin
                                w_state_nxt = ST_FLUSH;
                                w_cnt_nxt   = c_br_init;
                            end
                        end else if (w_hz) begin
                            w_idex_bubble = 1'b1;
                            w_stall_inc   = 1'b1;
                        end else if (id_valid && id_halt) begin
                            w_stall_inc = 1'b1;
                            w_state_nxt = ST_DRAIN;
                            w_cnt_nxt   = c_drain_init;
                        end else begin
                            w_pc_en   = 1'b1;
                            w_ifid_en = 1'b1;
                        end
                    end
                    ST_FLUSH: begin
                        w_pc_en       = 1'b1;
                        w_ifid_en     = 1'b1;
                        w_ifid_flush  = 1'b1;
                        w_idex_en     = 1'b1;
                        w_idex_bubble = 1'b1;
                        w_exmem_en    = 1'b1;
                        w_memwb_en    = 1'b1;
                        w_cnt_nxt     = r_cnt - 4'd1;
                        if (r_cnt <= 4'd1) begin
                            w_state_nxt = ST_RUN;
                            w_cnt_nxt   = 4'd0;
                        end
                    end
                    ST_DRAIN: begin
                        w_idex_en     = 1'b1;
                        w_idex_bubble = 1'b1;
                        w_exmem_en    = 1'b1;
                        w_memwb_en    = 1'b1;
                        w_stall_inc   = 1'b1;
                        w_cnt_nxt     = r_cnt - 4'd1;
                        if (r_cnt <= 4'd1) begin
                            w_state_nxt = ST_HALTED;
                            w_cnt_nxt   = 4'd0;
                        end
                    end
                    ST_HALTED: begin
                        w_halt_done = 1'b1;
                    end
                    default: begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = 4'd0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_cnt       <= 4'd0;
            r_stall_cnt <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_stall_inc && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign pc_en       = w_pc_en;
    assign ifid_en     = w_ifid_en;
    assign ifid_flush  = w_ifid_flush;
    assign idex_en     = w_idex_en;
    assign idex_bubble = w_idex_bubble;
    assign exmem_en    = w_exmem_en;
    assign memwb_en    = w_memwb_en;
    assign halt_done   = w_halt_done;
    assign stall_cnt   = r_stall_cnt;
    assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Directed self-checking bench for pipe_hazard_ctrl
//                (BR_FLUSH=2, DRAIN_CYCLES=3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_rs_used, id_rt_used, id_halt;
    logic [2:0]  id_rs, id_rt, idex_rd;
    logic        idex_memread, idex_regwrt, ex_br_taken, mem_busy;
    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_bubble;
    logic        exmem_en, memwb_en, halt_done;
    logic [15:0] stall_cnt;
    logic [2:0]  state;

    int checks   = 0;
    int failures = 0;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en, halt_done}
    wire [7:0] ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble,
                      exmem_en, memwb_en, halt_done};

    pipe_hazard_ctrl #(.BR_FLUSH(2), .DRAIN_CYCLES(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rs_used   (id_rs_used),
        .id_rt        (id_rt),
        .id_rt_used   (id_rt_used),
        .id_halt      (id_halt),
        .idex_memread (idex_memread),
        .idex_regwrt  (idex_regwrt),
        .idex_rd      (idex_rd),
        .ex_br_taken  (ex_br_taken),
        .mem_busy     (mem_busy),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .ifid_flush   (ifid_flush),
        .idex_en      (idex_en),
        .idex_bubble  (idex_bubble),
        .exmem_en     (exmem_en),
        .memwb_en     (memwb_en),
        .halt_done    (halt_done),
        .stall_cnt    (stall_cnt),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_valid = 1'b0; id_rs = 3'd0; id_rs_used = 1'b0;
        id_rt = 3'd0; id_rt_used = 1'b0; id_halt = 1'b0;
        idex_memread = 1'b0; idex_regwrt = 1'b0; idex_rd = 3'd0;
        ex_br_taken = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic set_hz();
        id_valid = 1'b1; idex_memread = 1'b1; idex_regwrt = 1'b1;
        idex_rd = 3'd3; id_rs = 3'd3; id_rs_used = 1'b1;
    endtask

    // Inputs change on negedge; combinational outputs sampled #1 later,
    // registered outputs sampled at the negedge following each posedge.
    initial begin
        rst = 1'b1;
        idle();
        @(negedge clk);
        #1 chk("rst_mask", ctl, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_state", state, 0);
        chk("rst_stall", stall_cnt, 0);
        #1 chk("idle_ctl", ctl, 8'hD6);

        // Load-use through rs, then rs unused, then through rt, then rd mismatch
        @(negedge clk);
        set_hz();
        #1 chk("lu_rs_ctl", ctl, 8'h1E);
        @(negedge clk);
        chk("lu_rs_stall", stall_cnt, 1);
        chk("lu_rs_state", state, 0);
        id_rs_used = 1'b0;
        #1 chk("lu_nouse_ctl", ctl, 8'hD6);
        @(negedge clk);
        chk("lu_nouse_stall", stall_cnt, 1);
        id_rt = 3'd3; id_rt_used = 1'b1;
        #1 chk("lu_rt_ctl", ctl, 8'h1E);
        @(negedge clk);
        chk("lu_rt_stall", stall_cnt, 2);
        idex_rd = 3'd5;
        #1 chk("lu_rdmiss_ctl", ctl, 8'hD6);
        @(negedge clk);
        idle();

        // Branch coincident with hazard: branch wins, no stall
        set_hz();
        ex_br_taken = 1'b1;
        #1 chk("br_ctl", ctl, 8'hFE);
        @(negedge clk);
        chk("br_state", state, 1);
        chk("br_stall", stall_cnt, 2);
        idle();
        #1 chk("flush_ctl", ctl, 8'hFE);
        @(negedge clk);
        chk("flush_done_state", state, 0);
        #1 chk("post_flush_ctl", ctl, 8'hD6);

        // Freeze for 4 cycles inside FLUSH (cnt=1)
        ex_br_taken = 1'b1;
        @(negedge clk);
        idle();
        mem_busy = 1'b1;
        chk("frz_entry_state", state, 1);
        #1 chk("frz_ctl", ctl, 8'h00);
        repeat (4) @(negedge clk);
        chk("frz_state", state, 1);
        chk("frz_stall", stall_cnt, 6);
        mem_busy = 1'b0;
        #1 chk("frz_release_ctl", ctl, 8'hFE);
        @(negedge clk);
        chk("frz_exit_state", state, 0);

        // Halt and branch together: branch squashes the halt
        id_valid = 1'b1; id_halt = 1'b1; ex_br_taken = 1'b1;
        #1 chk("hvb_ctl", ctl, 8'hFE);
        @(negedge clk);
        chk("hvb_state", state, 1);
        idle();
        #1 chk("hvb_flush_ctl", ctl, 8'hFE);
        @(negedge clk);
        chk("hvb_exit_state", state, 0);

        // Halt with a 2-cycle freeze in the drain
        id_valid = 1'b1; id_halt = 1'b1;
        #1 chk("halt_ctl", ctl, 8'h16);
        @(negedge clk);
        chk("halt_state", state, 2);
        chk("halt_stall", stall_cnt, 7);
        idle();
        set_hz();
        ex_br_taken = 1'b1;
        #1 chk("drain1_ctl", ctl, 8'h1E);
        @(negedge clk);
        chk("drain1_state", state, 2);
        chk("drain1_stall", stall_cnt, 8);
        idle();
        mem_busy = 1'b1;
        #1 chk("drain_frz_ctl", ctl, 8'h00);
        repeat (2) @(negedge clk);
        chk("drain_frz_state", state, 2);
        chk("drain_frz_stall", stall_cnt, 10);
        mem_busy = 1'b0;
        #1 chk("drain2_ctl", ctl, 8'h1E);
        @(negedge clk);
        chk("drain2_state", state, 2);
        chk("drain2_stall", stall_cnt, 11);
        #1 chk("drain3_ctl", ctl, 8'h1E);
        @(negedge clk);
        chk("halted_state", state, 3);
        chk("halted_stall", stall_cnt, 12);
        #1 chk("halted_ctl", ctl, 8'h01);
        mem_busy = 1'b1;
        #1 chk("halted_busy_ctl", ctl, 8'h01);
        @(negedge clk);
        chk("halted_hold_state", state, 3);
        chk("halted_hold_stall", stall_cnt, 12);
        mem_busy = 1'b0;

        // Reset out of HALTED, then reset in DRAIN with cnt=2
        rst = 1'b1;
        #1 chk("rst_halted_ctl", ctl, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_halted_state", state, 0);
        id_valid = 1'b1; id_halt = 1'b1;
        @(negedge clk);
        idle();
        @(negedge clk);
        chk("rst_drain_pre_state", state, 2);
        chk("rst_drain_pre_stall", stall_cnt, 2);
        rst = 1'b1;
        #1 chk("rst_drain_ctl", ctl, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_drain_state", state, 0);
        chk("rst_drain_stall", stall_cnt, 0);
        #1 chk("rst_drain_ctl_after", ctl, 8'hD6);
        @(negedge clk);
        chk("rst_no_residual_state", state, 0);

        // Saturation of stall_cnt
        mem_busy = 1'b1;
        repeat (65534) @(negedge clk);
        chk("sat_pre", stall_cnt, 16'hFFFE);
        repeat (3) @(negedge clk);
        chk("sat_ffff", stall_cnt, 16'hFFFF);
        mem_busy = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
